// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: data width, header layout and
// control FSM state encodings.
package router_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int ADDR_W       = 2;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB  = 2;

    // Control FSM encodings, shared with router_fsm
    localparam logic [2:0] ST_DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] ST_LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] ST_LOAD_DATA          = 3'd2;
    localparam logic [2:0] ST_LOAD_PARITY        = 3'd3;
    localparam logic [2:0] ST_FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] ST_LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] ST_WAIT_TILL_EMPTY    = 3'd6;
    localparam logic [2:0] ST_CHECK_PARITY_ERROR = 3'd7;

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DEF_DATA_W-1:0] hdr);
        return hdr[HDR_ADDR_LSB +: ADDR_W];
    endfunction

endpackage

// File: rtl/router_if.sv
// Byte-stream bus between source, router register stage and FIFO write port.
interface router_if #(
    parameter int DATA_W = router_pkg::DEF_DATA_W
);
    logic              packet_valid;
    logic [DATA_W-1:0] data_in;
    logic              fifo_full;
    logic [DATA_W-1:0] dout;

    modport master (
        output packet_valid,
        output data_in,
        output fifo_full,
        input  dout
    );

    modport slave (
        input  packet_valid,
        input  data_in,
        input  fifo_full,
        output dout
    );
endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity over header and payload, compared with the received
// parity byte.
module router_parity_acc
    import router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              hdr_en,
    input  logic [DATA_W-1:0] hdr,
    input  logic              dat_en,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] pkt_parity,
    output logic [DATA_W-1:0] int_parity,
    output logic              mismatch
);

    always_ff @(posedge clk) begin
        if (reset)
            int_parity <= '0;
        else if (clr)
            int_parity <= '0;
        else if (hdr_en)
            int_parity <= int_parity ^ hdr;
        else if (dat_en)
            int_parity <= int_parity ^ data;
    end

    assign mismatch = (int_parity != pkt_parity);

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, full-stall hold byte,
// parity tracking and status back to the control FSM.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic        clk,
    input  logic        reset,
    router_if.slave     bus,
    input  logic        detect_add,
    input  logic        lfd_state,
    input  logic        ld_state,
    input  logic        laf_state,
    input  logic        full_state,
    input  logic        rst_int_reg,
    output logic        parity_done,
    output logic        low_packet_valid,
    output logic        err
);

    logic [DATA_W-1:0] hdr_byte;
    logic [DATA_W-1:0] hold_byte;
    logic [DATA_W-1:0] pkt_parity;
    logic [DATA_W-1:0] int_parity;
    logic              mismatch;
    logic              dat_en;
    logic              pdone_set;
    logic              lpv_set;

    assign dat_en    = ld_state && bus.packet_valid && !full_state;
    assign lpv_set   = ld_state && !bus.packet_valid;
    assign pdone_set = (ld_state && !bus.fifo_full && !bus.packet_valid)
                    || (laf_state && low_packet_valid && !parity_done);

    router_parity_acc #(.DATA_W(DATA_W)) u_par (
        .clk        (clk),
        .reset      (reset),
        .clr        (detect_add),
        .hdr_en     (lfd_state),
        .hdr        (hdr_byte),
        .dat_en     (dat_en),
        .data       (bus.data_in),
        .pkt_parity (pkt_parity),
        .int_parity (int_parity),
        .mismatch   (mismatch)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_byte  <= '0;
            hold_byte <= '0;
            bus.dout  <= '0;
        end else begin
            if (detect_add && bus.packet_valid)
                hdr_byte <= bus.data_in;
            // hold_byte only captures when the full-stall branch wins
            if (lfd_state)
                bus.dout <= hdr_byte;
            else if (ld_state && !bus.fifo_full)
                bus.dout <= bus.data_in;
            else if (ld_state)
                hold_byte <= bus.data_in;
            else if (laf_state)
                bus.dout <= hold_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_parity       <= '0;
            parity_done      <= 1'b0;
            low_packet_valid <= 1'b0;
            err              <= 1'b0;
        end else begin
            if (lpv_set)
                pkt_parity <= bus.data_in;
            if (pdone_set)
                parity_done <= 1'b1;
            else if (detect_add)
                parity_done <= 1'b0;
            if (rst_int_reg)
                low_packet_valid <= 1'b0;
            else if (lpv_set)
                low_packet_valid <= 1'b1;
            if (rst_int_reg && parity_done)
                err <= mismatch;
            else if (detect_add)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: directed packet scenarios plus
// randomized packets against a queue-based parity model.
module tb_router_reg;

    localparam int S_NONE = 0;
    localparam int S_DA   = 1;
    localparam int S_LFD  = 2;
    localparam int S_LD   = 3;
    localparam int S_LAF  = 4;
    localparam int S_FULL = 5;
    localparam int S_CPE  = 6;

    typedef struct {
        int         st;
        logic       pv;
        logic [7:0] d;
        logic       ff;
    } stim_t;

    logic clk = 1'b0;
    logic reset;
    logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic parity_done, low_packet_valid, err;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_hdr, m_hold, m_dout, m_pkt;
    logic       m_done, m_lpv, m_err;
    logic [7:0] q[$];
    stim_t      sq[$];

    router_if #(.DATA_W(8)) bus ();

    always #5 clk = ~clk;

    router_reg dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus.slave),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err)
    );

    function automatic logic [7:0] qxor();
        logic [7:0] r = 8'h00;
        foreach (q[i]) r ^= q[i];
        return r;
    endfunction

    // Drive one cycle and advance the packet-level model
    task automatic step(input int st, input logic pv, input logic [7:0] d,
                        input logic ff, input logic rst = 1'b0);
        reset           = rst;
        detect_add      = (st == S_DA);
        lfd_state       = (st == S_LFD);
        ld_state        = (st == S_LD);
        laf_state       = (st == S_LAF);
        full_state      = (st == S_FULL);
        rst_int_reg     = (st == S_CPE);
        bus.packet_valid = pv;
        bus.data_in      = d;
        bus.fifo_full    = ff;
        @(posedge clk);
        if (rst) begin
            m_hdr = 0; m_hold = 0; m_dout = 0; m_pkt = 0;
            m_done = 0; m_lpv = 0; m_err = 0;
            q.delete();
        end else begin
            case (st)
                S_DA: begin
                    if (pv) m_hdr = d;
                    q.delete();
                    m_done = 0;
                    m_err  = 0;
                end
                S_LFD: begin
                    m_dout = m_hdr;
                    q.push_back(m_hdr);
                end
                S_LD: begin
                    if (ff) m_hold = d;
                    else m_dout = d;
                    if (pv) q.push_back(d);
                    else begin
                        m_pkt = d;
                        m_lpv = 1;
                        if (!ff) m_done = 1;
                    end
                end
                S_LAF: begin
                    m_dout = m_hold;
                    if (m_lpv) m_done = 1;
                end
                S_CPE: begin
                    if (m_done) m_err = (qxor() != m_pkt);
                    m_lpv = 0;
                end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        step(S_NONE, 1'b1, 8'hFF, 1'b0, 1'b1);
        total++;
        if (bus.dout !== 8'h00 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_dout_err: dout=%h err=%b want 00/0", bus.dout, err);
        end
        total++;
        if (parity_done !== 1'b0 || low_packet_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: pd=%b lpv=%b want 0/0", parity_done, low_packet_valid);
        end
        step(S_NONE, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic run_clean(input logic [7:0] par, input string nm);
        logic [7:0] exp_d[5];
        logic [7:0] got_d[5];
        exp_d = '{8'h0D, 8'h11, 8'h22, 8'h33, par};
        step(S_DA, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h11, 1'b0);
        got_d[0] = bus.dout;
        step(S_LD, 1'b1, 8'h11, 1'b0);
        got_d[1] = bus.dout;
        step(S_LD, 1'b1, 8'h22, 1'b0);
        got_d[2] = bus.dout;
        step(S_LD, 1'b1, 8'h33, 1'b0);
        got_d[3] = bus.dout;
        step(S_LD, 1'b0, par, 1'b0);
        got_d[4] = bus.dout;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL %s_dout%0d: got %h want %h", nm, i, got_d[i], exp_d[i]);
            end
        end
        total++;
        if (parity_done !== 1'b1 || low_packet_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_pdone: pd=%b lpv=%b want 1/1", nm, parity_done, low_packet_valid);
        end
        step(S_CPE, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_clean();
        run_clean(8'h0D, "clean");
        total++;
        if (err !== 1'b0 || low_packet_valid !== 1'b0) begin
            bad++;
            $display("FAIL clean_err: err=%b lpv=%b want 0/0", err, low_packet_valid);
        end
    endtask

    task automatic test_bad_parity();
        run_clean(8'h0E, "badpar");
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL badpar_err: err=%b want 1", err);
        end
        step(S_NONE, 1'b0, 8'h00, 1'b0);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL badpar_hold: err=%b want 1", err);
        end
        step(S_DA, 1'b1, 8'h05, 1'b0);
        total++;
        if (err !== 1'b0 || parity_done !== 1'b0) begin
            bad++;
            $display("FAIL badpar_clear: err=%b pd=%b want 0/0", err, parity_done);
        end
    endtask

    task automatic test_full_mid();
        logic [7:0] seen[4];
        step(S_DA, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h22, 1'b1);
        seen[0] = bus.dout;
        step(S_FULL, 1'b1, 8'h5A, 1'b1);
        seen[1] = bus.dout;
        step(S_FULL, 1'b1, 8'hC3, 1'b1);
        seen[2] = bus.dout;
        step(S_LAF, 1'b1, 8'h33, 1'b0);
        seen[3] = bus.dout;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (seen[i] !== 8'h11) begin
                bad++;
                $display("FAIL full_hold%0d: dout=%h want 11", i, seen[i]);
            end
        end
        total++;
        if (seen[3] !== 8'h22) begin
            bad++;
            $display("FAIL full_laf: dout=%h want 22", seen[3]);
        end
        step(S_LD, 1'b1, 8'h33, 1'b0);
        step(S_LD, 1'b0, 8'h0D, 1'b0);
        step(S_CPE, 1'b0, 8'h00, 1'b0);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL full_err: err=%b want 0", err);
        end
    endtask

    task automatic test_end_during_full();
        step(S_DA, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h22, 1'b0);
        step(S_LD, 1'b1, 8'h33, 1'b0);
        step(S_LD, 1'b0, 8'h0D, 1'b1);
        total++;
        if (low_packet_valid !== 1'b1 || parity_done !== 1'b0) begin
            bad++;
            $display("FAIL endfull_ld: lpv=%b pd=%b want 1/0", low_packet_valid, parity_done);
        end
        step(S_LAF, 1'b0, 8'h00, 1'b0);
        total++;
        if (parity_done !== 1'b1 || bus.dout !== 8'h0D) begin
            bad++;
            $display("FAIL endfull_laf: pd=%b dout=%h want 1/0d", parity_done, bus.dout);
        end
        step(S_NONE, 1'b0, 8'h00, 1'b0);
        total++;
        if (parity_done !== 1'b1) begin
            bad++;
            $display("FAIL endfull_stay: pd=%b want 1", parity_done);
        end
        step(S_CPE, 1'b0, 8'h00, 1'b0);
        total++;
        if (low_packet_valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL endfull_cpe: lpv=%b err=%b want 0/0", low_packet_valid, err);
        end
    endtask

    task automatic test_reset_mid();
        step(S_DA, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h22, 1'b0);
        step(S_NONE, 1'b1, 8'h33, 1'b0, 1'b1);
        total++;
        if ({bus.dout, err, parity_done, low_packet_valid} !== 11'h0) begin
            bad++;
            $display("FAIL rstmid_state: dout=%h err=%b pd=%b lpv=%b want 0",
                     bus.dout, err, parity_done, low_packet_valid);
        end
        step(S_DA, 1'b1, 8'h05, 1'b0);
        step(S_LFD, 1'b1, 8'hAA, 1'b0);
        step(S_LD, 1'b1, 8'hAA, 1'b0);
        step(S_LD, 1'b0, 8'hAF, 1'b0);
        step(S_CPE, 1'b0, 8'h00, 1'b0);
        total++;
        if (err !== 1'b0 || bus.dout !== 8'hAF) begin
            bad++;
            $display("FAIL rstmid_pkt: err=%b dout=%h want 0/af", err, bus.dout);
        end
    endtask

    function automatic stim_t mk(int st, logic pv, logic [7:0] d, logic ff);
        stim_t s;
        s.st = st; s.pv = pv; s.d = d; s.ff = ff;
        return s;
    endfunction

    task automatic gen_pkt();
        int         n;
        logic [7:0] hdr, par, b;
        logic [7:0] pay[$];
        n   = $urandom_range(1, 6);
        hdr = {n[5:0], 2'($urandom_range(0, 2))};
        par = hdr;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            pay.push_back(b);
            par ^= b;
        end
        if ($urandom_range(0, 3) == 0) par ^= 8'(1 << $urandom_range(0, 7));
        sq.push_back(mk(S_DA, 1'b1, hdr, 1'b0));
        sq.push_back(mk(S_LFD, 1'b1, pay[0], 1'b0));
        foreach (pay[i]) begin
            if ($urandom_range(0, 4) == 0) begin
                sq.push_back(mk(S_LD, 1'b1, pay[i], 1'b1));
                for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                    sq.push_back(mk(S_FULL, 1'b1, 8'($urandom), 1'b1));
                sq.push_back(mk(S_LAF, 1'b1, 8'($urandom), 1'b0));
            end else begin
                sq.push_back(mk(S_LD, 1'b1, pay[i], 1'b0));
            end
        end
        if ($urandom_range(0, 3) == 0) begin
            sq.push_back(mk(S_LD, 1'b0, par, 1'b1));
            sq.push_back(mk(S_LAF, 1'b0, 8'($urandom), 1'b0));
        end else begin
            sq.push_back(mk(S_LD, 1'b0, par, 1'b0));
        end
        sq.push_back(mk(S_CPE, 1'b0, 8'($urandom), 1'b0));
        if ($urandom_range(0, 1) == 0)
            sq.push_back(mk(S_NONE, 1'b0, 8'($urandom), 1'b0));
    endtask

    task automatic test_random();
        sq.delete();
        for (int p = 0; p < 40; p++) gen_pkt();
        foreach (sq[i]) begin
            step(sq[i].st, sq[i].pv, sq[i].d, sq[i].ff);
            total++;
            if ({bus.dout, err, parity_done, low_packet_valid} !==
                {m_dout, m_err, m_done, m_lpv}) begin
                bad++;
                $display("FAIL rand_%0d: dout=%h err=%b pd=%b lpv=%b want %h %b %b %b",
                         i, bus.dout, err, parity_done, low_packet_valid,
                         m_dout, m_err, m_done, m_lpv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bad_parity();
        test_full_mid();
        test_end_during_full();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
